// File: rtl/gpio_pkg.sv
// Shared defaults and helpers for the GPIO pad block.
package gpio_pkg;

    localparam int GPIO_WIDTH           = 16;
    localparam int GPIO_SYNC_STAGES     = 2;
    localparam int GPIO_DEBOUNCE_CYCLES = 0;

    // Debounce counter width; never narrower than 1 bit so the bypass build stays legal.
    function automatic int cnt_width(input int d);
        return (d < 1) ? 1 : $clog2(d + 1);
    endfunction

endpackage

// File: rtl/gpio_bit_filter.sv
// Single-pin input conditioning: synchroniser, optional debounce, stable level
// and same-edge rise/fall pulses derived from the next stable value.
module gpio_bit_filter
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic pad_in,
    output logic ps,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   s;
    logic                   stable_q;
    logic                   stable_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pad_in};
    end

    assign s = sync_pipe[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign stable_next = s;
    end else begin : g_debounce
        localparam int CW = cnt_width(DEBOUNCE_CYCLES);
        localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // Any sample that agrees with the current level restarts the run.
        always_comb begin
            stable_next = stable_q;
            cnt_d       = cnt_q;
            if (s == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_next = s;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stable_q <= 1'b0;
        else        stable_q <= stable_next;
    end

    assign ps   = stable_q;
    assign rise = stable_next & ~stable_q;
    assign fall = ~stable_next & stable_q;

endmodule

// File: rtl/gpio_port.sv
// GPIO pad block: per-pin tristate drive, filtered input path, sticky edge
// interrupt status and a combined interrupt line.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH,
    parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] gpio_pad,
    input  logic [WIDTH-1:0] gpio_dr,
    input  logic [WIDTH-1:0] gpio_ts,
    output logic [WIDTH-1:0] gpio_ps,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] irq_clr,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
);

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] set;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        // Drive is purely combinational so pads stay under control in reset.
        assign gpio_pad[i] = gpio_ts[i] ? gpio_dr[i] : 1'bz;

        gpio_bit_filter #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_filt (
            .clk    (clk),
            .reset  (reset),
            .pad_in (gpio_pad[i]),
            .ps     (gpio_ps[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    assign set = (rise & rise_en) | (fall & fall_en);

    // A new edge on the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_status <= '0;
        else        irq_status <= set | (irq_status & ~irq_clr);
    end

    assign irq = |irq_status;

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: three builds (D=0, D=4, 3-stage sync) on one clock.
module tb_gpio_port;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   hi;

    always #5 clk = ~clk;

    // Build A: 16 pins, 2 sync stages, debounce bypass
    wire  [15:0] pad0;
    logic [15:0] dr0, ts0, oe0, ev0, ren0, fen0, clr0, ps0, st0;
    logic        irq0;
    for (genvar i = 0; i < 16; i++) begin : g_ext0
        assign pad0[i] = oe0[i] ? ev0[i] : 1'bz;
    end

    // Build B: 16 pins, 2 sync stages, debounce 4
    wire  [15:0] pad4;
    logic [15:0] ext4, ren4, fen4, clr4, ps4, st4;
    logic        irq4;
    assign pad4 = ext4;

    // Build C: 4 pins, 3 sync stages, debounce bypass
    wire  [3:0] pad3;
    logic [3:0] ext3, ren3, fen3, clr3, ps3, st3;
    logic       irq3;
    assign pad3 = ext3;

    gpio_port #(.WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) u_d0 (
        .clk(clk), .reset(reset), .gpio_pad(pad0), .gpio_dr(dr0), .gpio_ts(ts0),
        .gpio_ps(ps0), .rise_en(ren0), .fall_en(fen0), .irq_clr(clr0),
        .irq_status(st0), .irq(irq0)
    );

    gpio_port #(.WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_d4 (
        .clk(clk), .reset(reset), .gpio_pad(pad4), .gpio_dr(16'h0000), .gpio_ts(16'h0000),
        .gpio_ps(ps4), .rise_en(ren4), .fall_en(fen4), .irq_clr(clr4),
        .irq_status(st4), .irq(irq4)
    );

    gpio_port #(.WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0)) u_s3 (
        .clk(clk), .reset(reset), .gpio_pad(pad3), .gpio_dr(4'h0), .gpio_ts(4'h0),
        .gpio_ps(ps3), .rise_en(ren3), .fall_en(fen3), .irq_clr(clr3),
        .irq_status(st3), .irq(irq3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        dr0 = 16'hA5A5; ts0 = 16'h00FF; oe0 = 16'hFF00; ev0 = 16'h3C00;
        ren0 = '0; fen0 = '0; clr0 = '0;
        ext4 = '0; ren4 = '0; fen4 = '0; clr4 = '0;
        ext3 = '0; ren3 = '0; fen3 = '0; clr3 = '0;

        // reset state, pad drive live during reset
        repeat (3) tick();
        chk("rst_ps0",  ps0,  0);
        chk("rst_st0",  st0,  0);
        chk("rst_irq0", irq0, 0);
        chk("rst_ps4",  ps4,  0);
        chk("rst_st4",  st4,  0);
        chk("rst_ps3",  ps3,  0);
        chk("rst_pad0", pad0, 16'h3CA5);

        // 1: mixed drive/external, 3-edge latency
        reset = 1'b1;
        repeat (2) tick();
        chk("t1_ps_e2", ps0, 16'h0000);
        tick();
        chk("t1_ps_e3", ps0, 16'h3CA5);
        chk("t1_pad",   pad0, 16'h3CA5);
        chk("t1_irq0",  irq0, 0);

        // 2: debounced rise lands on edge 6 with irq on the same edge
        ren4 = 16'h0001;
        ext4[0] = 1'b1;
        repeat (5) tick();
        chk("t2_ps_e5", ps4, 16'h0000);
        chk("t2_st_e5", st4, 16'h0000);
        tick();
        chk("t2_ps_e6",  ps4,  16'h0001);
        chk("t2_st_e6",  st4,  16'h0001);
        chk("t2_irq_e6", irq4, 1);
        clr4 = 16'h0001;
        tick();
        chk("t2_clr", st4, 16'h0000);
        clr4 = '0;
        ext4[0] = 1'b0;

        // 3: 3-cycle glitch rejected, 4-cycle pulse accepted for 4 cycles
        ren4 = 16'h0002;
        ext4[1] = 1'b1;
        repeat (3) tick();
        ext4[1] = 1'b0;
        hi = 0;
        repeat (10) begin
            tick();
            if (ps4[1]) hi++;
        end
        chk("t3_glitch_hi", hi, 0);
        chk("t3_glitch_st", st4, 16'h0000);
        ext4[1] = 1'b1;
        repeat (4) tick();
        ext4[1] = 1'b0;
        hi = 0;
        repeat (12) begin
            tick();
            if (ps4[1]) hi++;
        end
        chk("t3_pulse_hi", hi, 4);
        chk("t3_pulse_st", st4, 16'h0002);
        clr4 = 16'h0002;
        tick();
        clr4 = '0;
        chk("t3_clr", st4, 16'h0000);

        // 4: falling-only enable, set-wins against clear
        ren4 = 16'h0000;
        fen4 = 16'h0004;
        ext4[2] = 1'b1;
        repeat (8) tick();
        chk("t4_ps_hi",     ps4[2], 1);
        chk("t4_rise_off",  st4, 16'h0000);
        ext4[2] = 1'b0;
        repeat (6) tick();
        chk("t4_fall_set",  st4, 16'h0004);
        chk("t4_irq",       irq4, 1);
        ext4[2] = 1'b1;
        repeat (8) tick();
        chk("t4_rise_keep", st4, 16'h0004);
        ext4[2] = 1'b0;
        repeat (5) tick();
        clr4 = 16'h0004;
        tick();
        chk("t4_set_wins",  st4, 16'h0004);
        tick();
        chk("t4_clr_only",  st4, 16'h0000);
        chk("t4_irq_low",   irq4, 0);
        clr4 = '0;

        // 5: async reset mid-debounce, then rise after 2+D edges
        fen4 = 16'h0000;
        ren4 = 16'h000C;
        ext4[2] = 1'b1;
        repeat (6) tick();
        chk("t5_pre_st", st4, 16'h0004);
        ext4[3] = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        #2;
        chk("t5_rst_ps",  ps4,  16'h0000);
        chk("t5_rst_st",  st4,  16'h0000);
        chk("t5_rst_irq", irq4, 0);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        chk("t5_st_e5", st4, 16'h0000);
        tick();
        chk("t5_st_e6",  st4,  16'h000C);
        chk("t5_ps_e6",  ps4,  16'h000C);
        chk("t5_irq_e6", irq4, 1);

        // 6: 3-stage sync, bypass debounce
        ren3 = 4'h5;
        ext3 = 4'hF;
        repeat (3) tick();
        chk("t6_ps_e3", ps3, 4'h0);
        tick();
        chk("t6_ps_e4",  ps3,  4'hF);
        chk("t6_st_e4",  st3,  4'h5);
        chk("t6_irq_e4", irq3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
Name: gpio_port

Overview:
Parametrised GPIO pad block for the RISC-V microcontroller. It provides per-pin tristate output drive and a metastability-safe input path with a synchroniser and optional debounce. Edge detection sets sticky per-pin interrupt status, and the block produces one combined interrupt line. It sits between the top-level pads and the GPIO register file, and replaces the fixed 16-bit combinational pad mux.

Parameters:
WIDTH, 16, number of GPIO pins
SYNC_STAGES, 2, input synchroniser flops per pin (legal 2..4)
DEBOUNCE_CYCLES, 0, consecutive stable synchronised samples required to accept a new level; 0 = debounce bypass

Ports:
clk  input  1  master clock
reset  input  1  asynchronous, active-low reset
gpio_pad  inout  WIDTH  bidirectional pins
gpio_dr  input  WIDTH  output data register value
gpio_ts  input  WIDTH  per-pin drive enable; 1 = drive gpio_dr onto pad, 0 = hi-Z
gpio_ps  output  WIDTH  pin state: synchronised, debounced pad level
rise_en  input  WIDTH  per-pin rising-edge interrupt enable
fall_en  input  WIDTH  per-pin falling-edge interrupt enable
irq_clr  input  WIDTH  per-pin clear of irq_status, level-sensitive, sampled each clk
irq_status  output  WIDTH  sticky per-pin edge-detected flags
irq  output  1  OR of irq_status

Behaviour:
- Reset: the clock and reset ports are named clk and reset; reset is asynchronous and active-low. When reset = 0, all sync flops, stable levels, debounce counters and irq_status clear to 0, so gpio_ps = 0 and irq = 0. Release of reset is synchronous to the next clk edge.
- Pad drive:
  - Combinational and per bit, with no clock: gpio_pad[i] = gpio_ts[i] ? gpio_dr[i] : 1'bz.
  - Drive is active even during reset.
- Input path, per pin i:
  - The pad is sampled into a chain of SYNC_STAGES flops; the last flop output is s[i].
  - Driven pins loop back, so gpio_ps reflects gpio_dr after the input-path latency.
- Debounce, DEBOUNCE_CYCLES = D > 0:
  - Counter width is $clog2(D+1).
  - Each edge:
    - if s == stable, cnt <= 0;
    - else if cnt == D-1, stable <= s and cnt <= 0;
    - else cnt <= cnt+1.
  - Any sample equal to stable restarts the count. A glitch shorter than D synchronised cycles is never accepted.
- Bypass, D = 0: stable <= s every edge.
- gpio_ps = stable, registered.
- Latency, pad change to gpio_ps:
  - SYNC_STAGES + D edges for D > 0;
  - SYNC_STAGES + 1 edges for D = 0.
- Edge detection: computed on the stable update.
  - rise[i] = stable_next & ~stable; fall[i] = ~stable_next & stable.
  - On the same edge that stable updates: set[i] = (rise[i] & rise_en[i]) | (fall[i] & fall_en[i]).
- irq_status update: irq_status[i] <= set[i] | (irq_status[i] & ~irq_clr[i]).
  - Set and clear on the same edge: set wins.
  - Clearing an already-clear bit has no effect.
  - Disabling rise_en/fall_en does not clear already-set status.
- irq = |irq_status, combinational from registers, so no extra latency.
- Edges that occur during reset are never recorded. The first edge after reset is evaluated relative to stable = 0.

Decomposition:
- Package gpio_pkg holds the default WIDTH, SYNC_STAGES and DEBOUNCE_CYCLES constants, plus the localparam function for counter width.
- One sub-module, gpio_bit_filter: a single-pin synchroniser, debounce counter, stable register and rise/fall pulse outputs.
- gpio_port generates WIDTH instances of gpio_bit_filter, plus the tristate assigns and the irq_status/irq logic.

Test Plan:
1. WIDTH=16, SYNC_STAGES=2, D=0; gpio_ts=16'h00FF, gpio_dr=16'hA5A5, pads 15:8 driven externally to 8'h3C -> pad reads 16'h3CA5; gpio_ps = 16'h3CA5 exactly 3 edges after the inputs settle.
2. D=4, external pad[0] 0->1 held -> gpio_ps[0] rises on edge 6 (2+4); rise_en[0]=1 -> irq_status[0]=1 and irq=1 on that same edge.
3. D=4, pad[1] glitch high for 3 cycles then low -> gpio_ps[1] stays 0, irq_status stays 0; repeat with a 4-cycle pulse -> gpio_ps[1] pulses high for 4 cycles.
4. fall_en[2]=1, rise_en[2]=0, pad[2] 1->0 -> irq_status[2] sets; a rising transition leaves it unchanged; irq_clr[2] held high on the edge a new falling edge arrives -> bit remains 1 (set wins); irq_clr alone -> 0, irq=0.
5. Assert reset low mid-debounce (count at 2) and with irq_status=16'h0004 -> all outputs 0 immediately, without a clock; after release, pad held high with rise_en set -> irq_status sets after 2+D edges.
6. SYNC_STAGES=3, WIDTH=4, D=0, step pad 4'h0 -> 4'hF -> gpio_ps = 4'hF on edge 4; rise_en=4'h5 -> irq_status=4'h5.
